execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  Execute stage of the 5-stage pipeline: consumes the D->E register outputs, applies
//  forwarding, runs the ALU, evaluates the ARM condition against an internal NZCV flags
//  register, gates the control bits, and holds the E->M pipeline register.
//  Combinational branch outputs go to the fetch stage; registered M-side outputs feed memory.
// PARAMETERS
//  WIDTH  32  datapath width (operands, ALU result, write data)
//  RAW    4   register-address width (WA3)
// PORTS
//  clk          in  1      clock, rising edge
//  reset        in  1      asynchronous, active-high reset
//  PCSrcE/MemtoRegE/MemWriteE/ALUSrcE/RegWriteE/BranchE  in 1  decoded controls from D->E register
//  ALUControlE  in  3      ALU op (encodings below)
//  FlagWriteE   in  2      [1] write N,Z; [0] write C,V
//  CondE        in  4      ARM condition field
//  Rd1E, Rd2E   in  WIDTH  register-file operands
//  ExtImmE      in  WIDTH  extended immediate
//  WA3E         in  RAW    destination register
//  ForwardAE/BE in  2      00 RdxE, 01 ResultW, 10 ALUResultM, 11 RdxE
//  ResultW      in  WIDTH  writeback result (forward source)
//  EnM          in  1      1 = E->M register loads; 0 = hold
//  FlushM       in  1      1 = load a bubble into E->M
//  ALUResultE   out WIDTH  combinational ALU result (branch target)
//  BranchTakenE out 1      combinational: (BranchE | PCSrcE) & CondExE
//  PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out 1  registered gated controls
//  ALUResultM, WriteDataM  out WIDTH  registered; WA3M out RAW registered
//  FlagsE       out 4      current NZCV register {N,Z,C,V}
// BEHAVIOUR
//  - Reset (async, any time): all M outputs and FlagsE -> 0 immediately; in-flight instr lost.
//  - SrcA = fwd(Rd1E,ForwardAE); WriteDataE = fwd(Rd2E,ForwardBE); SrcB = ALUSrcE?ExtImmE:WriteDataE.
//  - ALU: 000 ADD, 001 SUB(A-B), 010 AND, 011 ORR, 100 EOR, 101 MOV(=SrcB), 110/111 -> 0.
//    N=res[31]; Z=(res==0); ADD: C=carry-out, V=signed ovf; SUB: C=1 iff A>=B unsigned,
//    V=signed ovf; all other ops C=V=0. Arithmetic modulo 2^WIDTH.
//  - CondExE from CondE vs FlagsE (pre-update value): EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N,
//    VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
//  - Gated: RegWrite/MemWrite/PCSrc = raw & CondExE; MemtoReg ungated.
//  - Flags: at posedge, if EnM & CondExE: FlagWriteE[1] -> update N,Z; [0] -> update C,V.
//    New flags visible to the next instruction in E (1-cycle latency); no update while EnM=0.
//  - E->M register, latency 1: FlushM=1 -> all controls 0, ALUResultM/WriteDataM/WA3M 0
//    (FlushM wins over EnM=0); else EnM=1 -> load; else hold all M outputs.
//  - ForwardAE/BE=10 uses the currently registered ALUResultM (pre-edge value).
// STRUCTURE
//  - Shared header pipeline_defs.vh: ALU op codes, condition codes, forward-select codes.
//  - Sub-module exec_alu (combinational: SrcA, SrcB, ALUControl -> result, NZCV).
//  - execute_stage holds forwarding muxes, condition check, flags register, E->M register.
// TESTING
//  1 reset mid-run: reset=1 between edges -> all M outputs and FlagsE 0 before next edge.
//  2 SUB 5-7, FlagWrite=11, AL: ALUResultM=0xFFFFFFFE, next cycle FlagsE=1000 (N=1,C=0).
//  3 ADD 0x7FFFFFFF+1 with S -> FlagsE=1001; following BEQ-type CondE=0000 -> BranchTakenE=0.
//  4 Forwarding: ForwardAE=10 with ALUResultM=0x10, Rd1E=0, ADD imm 4 -> ALUResultE=0x14;
//    ForwardBE=01 ResultW=0xAB, MemWrite -> WriteDataM=0xAB.
//  5 CondE=0001 with Z=1, RegWriteE=MemWriteE=1 -> RegWriteM=MemWriteM=0, flags unchanged.
//  6 EnM=0 two cycles with FlagWrite set: M outputs and FlagsE hold; EnM=0 & FlushM=1 -> bubble.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared codes and helpers for the execute stage
// Purpose: ALU op codes, ARM condition codes, forward-select codes,
//          E->M control bundle and the condition evaluation helper.
// Ports:   none (package)
package execute_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_EOR = 3'b100,
    ALU_MOV = 3'b101
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  localparam logic [1:0] FWD_RD   = 2'b00;
  localparam logic [1:0] FWD_RESW = 2'b01;
  localparam logic [1:0] FWD_ALUM = 2'b10;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic memtoreg;
  } m_ctl_t;

  // nzcv is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = nzcv;
    case (cond_e'(cond))
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_stage_exec_alu.sv
// rtl/execute_stage_exec_alu.sv - combinational ALU with NZCV generation
// Purpose: computes result and {N,Z,C,V} for the execute stage.
// Ports:   i_src_a, i_src_b (WIDTH) operands; i_alu_control (3) op;
//          o_result (WIDTH); o_nzcv (4) {N,Z,C,V}.
module exec_alu
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic [2:0]       i_alu_control,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_nzcv
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_sum  = {1'b0, i_src_a} + {1'b0, i_src_b};
  assign w_diff = {1'b0, i_src_a} - {1'b0, i_src_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_op_e'(i_alu_control))
      ALU_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_src_a[WIDTH-1] == i_src_b[WIDTH-1]) && (w_res[WIDTH-1] != i_src_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        // borrow out of the extended subtract means A < B unsigned
        w_c   = ~w_diff[WIDTH];
        w_v   = (i_src_a[WIDTH-1] != i_src_b[WIDTH-1]) && (w_res[WIDTH-1] != i_src_a[WIDTH-1]);
      end
      ALU_AND: w_res = i_src_a & i_src_b;
      ALU_ORR: w_res = i_src_a | i_src_b;
      ALU_EOR: w_res = i_src_a ^ i_src_b;
      ALU_MOV: w_res = i_src_b;
      default: w_res = '0;
    endcase
  end

  assign o_result = w_res;
  assign o_nzcv   = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - pipeline execute stage with flags and E->M register
// Purpose: forwarding muxes, ALU, condition check against the NZCV register,
//          control gating and the E->M pipeline register.
// Ports:   clk/reset; decoded controls, operands and WA3E from D->E;
//          ForwardAE/BE + ResultW forwarding; EnM/FlushM register control;
//          ALUResultE/BranchTakenE combinational to fetch; registered M-side
//          outputs; FlagsE current {N,Z,C,V}.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RAW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             ALUSrcE,
  input  logic             RegWriteE,
  input  logic             BranchE,
  input  logic [2:0]       ALUControlE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic [WIDTH-1:0] Rd1E,
  input  logic [WIDTH-1:0] Rd2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic [RAW-1:0]   WA3E,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             EnM,
  input  logic             FlushM,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             BranchTakenE,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [RAW-1:0]   WA3M,
  output logic [3:0]       FlagsE
);

  logic [3:0]       r_flags;
  m_ctl_t           r_ctl_m;
  logic [WIDTH-1:0] r_alu_result_m;
  logic [WIDTH-1:0] r_write_data_m;
  logic [RAW-1:0]   r_wa3_m;

  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_write_data_e;
  logic [WIDTH-1:0] w_src_b;
  logic [3:0]       w_alu_nzcv;
  logic             w_cond_ex;
  m_ctl_t           w_ctl_e;

  // 11 falls back to the register-file operand, same as 00
  always_comb begin
    case (ForwardAE)
      FWD_RESW: w_src_a = ResultW;
      FWD_ALUM: w_src_a = r_alu_result_m;
      default:  w_src_a = Rd1E;
    endcase
    case (ForwardBE)
      FWD_RESW: w_write_data_e = ResultW;
      FWD_ALUM: w_write_data_e = r_alu_result_m;
      default:  w_write_data_e = Rd2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ExtImmE : w_write_data_e;

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .i_src_a       (w_src_a),
    .i_src_b       (w_src_b),
    .i_alu_control (ALUControlE),
    .o_result      (ALUResultE),
    .o_nzcv        (w_alu_nzcv)
  );

  // evaluated against the flags before this instruction's own update
  assign w_cond_ex    = cond_pass(CondE, r_flags);
  assign BranchTakenE = (BranchE | PCSrcE) & w_cond_ex;

  assign w_ctl_e.pcsrc    = PCSrcE & w_cond_ex;
  assign w_ctl_e.regwrite = RegWriteE & w_cond_ex;
  assign w_ctl_e.memwrite = MemWriteE & w_cond_ex;
  assign w_ctl_e.memtoreg = MemtoRegE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (EnM && w_cond_ex) begin
      if (FlagWriteE[1]) r_flags[3:2] <= w_alu_nzcv[3:2];
      if (FlagWriteE[0]) r_flags[1:0] <= w_alu_nzcv[1:0];
    end
  end

  // flush takes priority over a stalled (EnM=0) register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctl_m        <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_wa3_m        <= '0;
    end else if (FlushM) begin
      r_ctl_m        <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_wa3_m        <= '0;
    end else if (EnM) begin
      r_ctl_m        <= w_ctl_e;
      r_alu_result_m <= ALUResultE;
      r_write_data_m <= w_write_data_e;
      r_wa3_m        <= WA3E;
    end
  end

  assign PCSrcM     = r_ctl_m.pcsrc;
  assign RegWriteM  = r_ctl_m.regwrite;
  assign MemWriteM  = r_ctl_m.memwrite;
  assign MemtoRegM  = r_ctl_m.memtoreg;
  assign ALUResultM = r_alu_result_m;
  assign WriteDataM = r_write_data_m;
  assign WA3M       = r_wa3_m;
  assign FlagsE     = r_flags;

endmodule
